adder_result_display: RTL and testbench

//  Downstream stage of the 3-bit ripple adder: captures operands X, Y and result {Cout,S}.

---
 rtl/adder_result_display_if.sv | 23 ++
 rtl/adder_result_display.sv | 127 ++++++++++++
 tb/tb_adder_result_display.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/adder_result_display_if.sv
// Signal bundle between the ripple adder's outputs, the display stage and the board's display pins.
interface adder_result_display_if;
    logic       capture;
    logic [2:0] x_in;
    logic [2:0] y_in;
    logic [2:0] s_in;
    logic       cout_in;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;

    // Upstream side: the adder stage and the board pins
    modport master (
        output capture, x_in, y_in, s_in, cout_in,
        input  seg, an, dp
    );

    // Display stage side
    modport slave (
        input  capture, x_in, y_in, s_in, cout_in,
        output seg, an, dp
    );
endinterface

// File: rtl/adder_result_display.sv
// Holds adder operands and result, and scans them onto a 4-digit multiplexed common-anode
// 7-segment display: digit3 = X, digit2 = Y, digits1..0 = decimal sum.
module adder_result_display #(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic                  clk,
    input  logic                  rst,
    adder_result_display_if.slave bus
);

    localparam int unsigned CNT_W     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned DIGIT_W   = 4;
    localparam int unsigned SEG_W     = 7;
    localparam int unsigned AN_W      = 4;
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [SEG_W-1:0]   SEG_BLANK = 7'b1111111;
    localparam logic [DIGIT_W-1:0] DIG_BLANK = 4'hF;

    logic [2:0]         x_q;
    logic [2:0]         y_q;
    logic [3:0]         sum_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [1:0]         idx_q;
    logic [SEG_W-1:0]   seg_q;
    logic [AN_W-1:0]    an_q;
    logic               dp_q;

    logic               wrap_c;
    logic [CNT_W-1:0]   cnt_next_c;
    logic [1:0]         idx_next_c;
    logic               tens_c;
    logic [3:0]         ones_c;
    logic [DIGIT_W-1:0] digit_c;
    logic [SEG_W-1:0]   seg_next_c;
    logic [AN_W-1:0]    an_next_c;
    logic               dp_next_c;

    // Active-low gfedcba pattern for one decimal digit; anything else stays dark
    function automatic logic [SEG_W-1:0] seg_code(input logic [DIGIT_W-1:0] v);
        logic [SEG_W-1:0] code;
        case (v)
            4'd0:    code = 7'b1000000;
            4'd1:    code = 7'b1111001;
            4'd2:    code = 7'b0100100;
            4'd3:    code = 7'b0110000;
            4'd4:    code = 7'b0011001;
            4'd5:    code = 7'b0010010;
            4'd6:    code = 7'b0000010;
            4'd7:    code = 7'b1111000;
            4'd8:    code = 7'b0000000;
            4'd9:    code = 7'b0010000;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

    // Refresh counter and digit index advance
    always_comb begin
        wrap_c     = (cnt_q == CNT_LAST);
        cnt_next_c = cnt_q;
        idx_next_c = idx_q;
        if (wrap_c) begin
            cnt_next_c = '0;
            idx_next_c = 2'(idx_q + 2'd1);
        end else begin
            cnt_next_c = CNT_W'(cnt_q + 1'b1);
        end
    end

    // Digit selection and decode from the current index and held values
    always_comb begin
        tens_c     = (sum_q >= 4'd10);
        ones_c     = tens_c ? 4'(sum_q - 4'd10) : sum_q;
        digit_c    = DIG_BLANK;
        case (idx_q)
            2'd0:    digit_c = ones_c;
            2'd1:    digit_c = tens_c ? 4'd1 : DIG_BLANK;
            2'd2:    digit_c = {1'b0, y_q};
            default: digit_c = {1'b0, x_q};
        endcase
        seg_next_c = seg_code(digit_c);
        an_next_c  = ~(4'b0001 << idx_q);
        dp_next_c  = (idx_q != 2'd2);
    end

    // Held operands and result; a capture never disturbs the scan
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q   <= '0;
            y_q   <= '0;
            sum_q <= '0;
        end else if (bus.capture) begin
            x_q   <= bus.x_in;
            y_q   <= bus.y_in;
            sum_q <= {bus.cout_in, bus.s_in};
        end
    end

    // Scan position
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_next_c;
            idx_q <= idx_next_c;
        end
    end

    // Pin drivers, dark while in reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q <= SEG_BLANK;
            an_q  <= '1;
            dp_q  <= 1'b1;
        end else begin
            seg_q <= seg_next_c;
            an_q  <= an_next_c;
            dp_q  <= dp_next_c;
        end
    end

    assign bus.seg = seg_q;
    assign bus.an  = an_q;
    assign bus.dp  = dp_q;

endmodule

// File: tb/tb_adder_result_display.sv
// Directed bench for adder_result_display: a cycle-count display model checked every cycle,
// plus hand-computed pins on reset, scan order, carry/boundary sums, mid-digit capture and async reset.
module tb_adder_result_display;

    localparam int unsigned DIV = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    adder_result_display_if bus ();
    adder_result_display_if bus1 ();

    adder_result_display #(.REFRESH_DIV(DIV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    adder_result_display #(.REFRESH_DIV(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, required %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural display model: which digit is lit follows from the edge count since reset
    localparam logic [6:0] SEG_TAB [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                            7'b0000000, 7'b0010000};

    function automatic logic [11:0] model_out(input int unsigned edges, input int mx, input int my,
                                              input int msum);
        int unsigned pos;
        int          tens;
        int          ones;
        int          val;
        logic [6:0]  s;
        logic [3:0]  a;
        pos  = (edges / DIV) % 4;
        tens = (msum >= 10) ? 1 : 0;
        ones = (tens == 1) ? msum - 10 : msum;
        case (pos)
            0:       val = ones;
            1:       val = (tens == 1) ? 1 : -1;
            2:       val = my;
            default: val = mx;
        endcase
        s = (val >= 0 && val <= 9) ? SEG_TAB[val] : 7'b1111111;
        a = 4'b1111;
        a[pos] = 1'b0;
        return {s, a, (pos == 2) ? 1'b0 : 1'b1};
    endfunction

    int unsigned m_edges = 0;
    int          m_x = 0;
    int          m_y = 0;
    int          m_sum = 0;
    logic [11:0] m_exp = {7'b1111111, 4'b1111, 1'b1};

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_edges <= 0;
            m_x     <= 0;
            m_y     <= 0;
            m_sum   <= 0;
            m_exp   <= {7'b1111111, 4'b1111, 1'b1};
        end else begin
            m_exp   <= model_out(m_edges, m_x, m_y, m_sum);
            m_edges <= m_edges + 1;
            if (bus.capture) begin
                m_x   <= int'(bus.x_in);
                m_y   <= int'(bus.y_in);
                m_sum <= int'({bus.cout_in, bus.s_in});
            end
        end
    end

    // Every-cycle comparison away from the active edge
    always @(negedge clk) begin
        check("model", {bus.seg, bus.an, bus.dp}, m_exp);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_capture(input logic [2:0] x, input logic [2:0] y, input logic [2:0] s,
                              input logic c);
        @(negedge clk);
        bus.capture = 1'b1;
        bus.x_in    = x;
        bus.y_in    = y;
        bus.s_in    = s;
        bus.cout_in = c;
        @(negedge clk);
        bus.capture = 1'b0;
    endtask

    // Advance to the first cycle of a freshly lit target digit, bounded
    task automatic wait_an(input logic [3:0] target);
        int n;
        n = 0;
        while (bus.an == target && n < 40) begin
            tick();
            n++;
        end
        while (bus.an != target && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_an: an=%b never reached %b", bus.an, target);
        end
    endtask

    initial begin
        bus.capture  = 1'b0;
        bus.x_in     = '0;
        bus.y_in     = '0;
        bus.s_in     = '0;
        bus.cout_in  = 1'b0;
        bus1.capture = 1'b0;
        bus1.x_in    = '0;
        bus1.y_in    = '0;
        bus1.s_in    = '0;
        bus1.cout_in = 1'b0;

        // Reset held for 3 cycles -> dark
        repeat (3) @(posedge clk);
        #1;
        check("reset_dark", {bus.seg, bus.an, bus.dp}, {7'b1111111, 4'b1111, 1'b1});
        @(negedge clk);
        rst = 1'b0;

        // Scan order, 16-cycle period; second instance advances every cycle
        for (int k = 1; k <= 17; k++) begin
            tick();
            case (k)
                1:  check("first_lit", {bus.seg, bus.an, bus.dp}, {7'b1000000, 4'b1110, 1'b1});
                4:  check("idx0_hold", {8'b0, bus.an}, {8'b0, 4'b1110});
                5:  check("idx1_blank", {bus.seg, bus.an, bus.dp}, {7'b1111111, 4'b1101, 1'b1});
                9:  check("idx2_dp", {bus.seg, bus.an, bus.dp}, {7'b1000000, 4'b1011, 1'b0});
                13: check("idx3", {bus.seg, bus.an, bus.dp}, {7'b1000000, 4'b0111, 1'b1});
                17: check("period_wrap", {8'b0, bus.an}, {8'b0, 4'b1110});
                default: ;
            endcase
            case (k)
                1: check("div1_an0", {8'b0, bus1.an}, {8'b0, 4'b1110});
                2: check("div1_an1", {8'b0, bus1.an}, {8'b0, 4'b1101});
                3: check("div1_an2", {8'b0, bus1.an}, {8'b0, 4'b1011});
                4: check("div1_an3", {8'b0, bus1.an}, {8'b0, 4'b0111});
                5: check("div1_wrap", {8'b0, bus1.an}, {8'b0, 4'b1110});
                default: ;
            endcase
        end

        // Carry result: 7 + 7 = 14
        do_capture(3'd7, 3'd7, 3'b110, 1'b1);
        wait_an(4'b1110);
        check("sum14_ones", {5'b0, bus.seg}, {5'b0, 7'b0011001});
        wait_an(4'b1101);
        check("sum14_tens", {5'b0, bus.seg}, {5'b0, 7'b1111001});
        wait_an(4'b1011);
        check("sum14_y", {5'b0, bus.seg, bus.dp}, {5'b0, 7'b1111000, 1'b0});
        wait_an(4'b0111);
        check("sum14_x", {5'b0, bus.seg}, {5'b0, 7'b1111000});

        // Boundary sum 9
        do_capture(3'd4, 3'd5, 3'b001, 1'b1);
        wait_an(4'b1110);
        check("sum9_ones", {5'b0, bus.seg}, {5'b0, 7'b0010000});
        wait_an(4'b1101);
        check("sum9_tens", {5'b0, bus.seg}, {5'b0, 7'b1111111});

        // Boundary sum 10
        do_capture(3'd5, 3'd5, 3'b010, 1'b1);
        wait_an(4'b1110);
        check("sum10_ones", {5'b0, bus.seg}, {5'b0, 7'b1000000});
        wait_an(4'b1101);
        check("sum10_tens", {5'b0, bus.seg}, {5'b0, 7'b1111001});

        // Capture mid-digit during idx3
        do_capture(3'd2, 3'd3, 3'b101, 1'b0);
        wait_an(4'b0111);
        check("x2_shown", {5'b0, bus.seg}, {5'b0, 7'b0100100});
        @(negedge clk);
        bus.capture = 1'b1;
        bus.x_in    = 3'd5;
        tick();
        check("cap_edge", {bus.seg, bus.an, bus.dp}, {7'b0100100, 4'b0111, 1'b1});
        @(negedge clk);
        bus.capture = 1'b0;
        tick();
        check("cap_visible", {bus.seg, bus.an, bus.dp}, {7'b0010010, 4'b0111, 1'b1});

        // Async reset mid-scan during idx2
        wait_an(4'b1011);
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("async_dark", {bus.seg, bus.an, bus.dp}, {7'b1111111, 4'b1111, 1'b1});
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("restart", {bus.seg, bus.an, bus.dp}, {7'b1000000, 4'b1110, 1'b1});
        repeat (4) tick();
        check("restart_regs0", {bus.seg, bus.an, bus.dp}, {7'b1111111, 4'b1101, 1'b1});

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
